// File: rtl/lsu_data_mem.sv
// Pipelined byte-addressed data memory for the load/store unit: sized loads/stores,
// little-endian, tagged in-order responses after LATENCY cycles, clear sweep after reset.
module lsu_data_mem #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2,
    parameter int TAG_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             resp_we
);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WAW   = AW - 2;

    typedef enum logic {INIT, RUN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WAW-1:0] sweep_ptr;
    logic           init_we;

    logic [31:0]    mem [WORDS];

    logic [1:0]     off;
    logic [WAW-1:0] widx;
    logic           in_range;
    logic           err;
    logic           accept;
    logic [31:0]    rd_word;
    logic [3:0]     wr_be;
    logic [31:0]    wr_data;

    logic             vld_p   [LATENCY];
    logic [31:0]      rdata_p [LATENCY];
    logic [TAG_W-1:0] tag_p   [LATENCY];
    logic             err_p   [LATENCY];
    logic             we_p    [LATENCY];

    function automatic logic align_err(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return ofs[0];
            2'b10:   return ofs != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] ofs,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {ofs, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'b00:   return 4'b0001 << ofs;
            2'b01:   return 4'b0011 << ofs;
            default: return 4'b1111;
        endcase
    endfunction

    // Range check is a full 32-bit compare so high addresses never alias onto the array.
    assign off      = req_addr[1:0];
    assign widx     = req_addr[AW-1:2];
    assign in_range = req_addr < 32'(DEPTH_BYTES);
    assign err      = align_err(req_size, off) || !in_range;
    assign accept   = req_valid && req_ready && !reset;
    assign rd_word  = mem[widx];
    assign wr_be    = byte_en(req_size, off);
    assign wr_data  = req_wdata << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (sweep_ptr == '1) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        init_we   = 1'b0;
        case (state)
            INIT:    init_we   = !reset;
            RUN:     req_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)        sweep_ptr <= '0;
        else if (init_we) sweep_ptr <= sweep_ptr + WAW'(1);
    end

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[sweep_ptr] <= '0;
        end else if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Stage 0 captures at the accept edge; later stages are a plain delay line.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        rdata_p[0] <= (req_we || err) ? 32'h0 : extend_load(rd_word, off, req_size, req_unsigned);
        tag_p[0]   <= req_tag;
        err_p[0]   <= err;
        we_p[0]    <= req_we;
        for (int i = 1; i < LATENCY; i++) begin
            rdata_p[i] <= rdata_p[i-1];
            tag_p[i]   <= tag_p[i-1];
            err_p[i]   <= err_p[i-1];
            we_p[i]    <= we_p[i-1];
        end
    end

    // Output stage: payload is forced to zero whenever no response is presented.
    assign resp_valid = vld_p[LATENCY-1];
    assign resp_rdata = resp_valid ? rdata_p[LATENCY-1] : 32'h0;
    assign resp_tag   = resp_valid ? tag_p[LATENCY-1]   : '0;
    assign resp_err   = resp_valid && err_p[LATENCY-1];
    assign resp_we    = resp_valid && we_p[LATENCY-1];
endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: default, LATENCY=1/DEPTH=32 and LATENCY=8/DEPTH=32 instances
// share one request stream; each has its own scoreboard queue and byte-array model.
module tb_lsu_data_mem;
    localparam int TAG_W = 6;
    localparam int NDUT  = 3;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      rdata;
        logic             err;
        logic             we;
        int               due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;

    logic             rdy  [NDUT];
    logic             rv   [NDUT];
    logic [31:0]      rdat [NDUT];
    logic [TAG_W-1:0] rtag [NDUT];
    logic             rerr [NDUT];
    logic             rwe  [NDUT];

    exp_t       scb  [NDUT][$];
    logic [7:0] mmem [NDUT][1024];
    vec_t       tab  [$];
    int         n_vec  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    bit         mon_en = 0;

    lsu_data_mem #(.DEPTH_BYTES(1024), .LATENCY(2), .TAG_W(TAG_W)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(rv[0]), .resp_rdata(rdat[0]), .resp_tag(rtag[0]),
        .resp_err(rerr[0]), .resp_we(rwe[0]));

    lsu_data_mem #(.DEPTH_BYTES(32), .LATENCY(1), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(rv[1]), .resp_rdata(rdat[1]), .resp_tag(rtag[1]),
        .resp_err(rerr[1]), .resp_we(rwe[1]));

    lsu_data_mem #(.DEPTH_BYTES(32), .LATENCY(8), .TAG_W(TAG_W)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(rv[2]), .resp_rdata(rdat[2]), .resp_tag(rtag[2]),
        .resp_err(rerr[2]), .resp_we(rwe[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int depth_of(input int d);
        return (d == 0) ? 1024 : 32;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 8;
    endfunction

    task automatic model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (sz == 2'd3) || ((a & 32'(n - 1)) != 32'h0) || (a >= 32'(depth_of(d)));
        rd = 32'h0;
        v  = 32'h0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < n; i++) mmem[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mmem[d][int'(a) + i];
                if (!uns)
                    for (int i = n; i < 4; i++) v[8*i +: 8] = {8{v[8*n-1]}};
                rd = v;
            end
        end
    endtask

    task automatic add(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic er);
        vec_t v;
        v = '{we, sz, uns, a, wd, rd, er};
        tab.push_back(v);
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [TAG_W-1:0] tag,
                        input bit use_tab, input logic [31:0] trd, input logic terr);
        logic [31:0] rd;
        logic        er;
        exp_t        e;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_tag = tag;
        for (int d = 0; d < NDUT; d++) begin
            if (rdy[d]) begin
                model(d, we, sz, uns, a, wd, rd, er);
                if (d == 0 && use_tab) begin
                    rd = trd;
                    er = terr;
                end
                e.tag = tag; e.rdata = rd; e.err = er; e.we = we; e.due = cyc + lat_of(d);
                scb[d].push_back(e);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
            scb[d].delete();
            for (int i = 0; i < 1024; i++) mmem[d][i] = 8'h0;
        end
        repeat (n - 1) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if (rdy[d] || rv[d] || rdat[d] != 32'h0 || rtag[d] != '0 || rerr[d] || rwe[d]) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got ready=%b valid=%b rdata=%h tag=%0d err=%b we=%b, want all 0",
                         d, rdy[d], rv[d], rdat[d], rtag[d], rerr[d], rwe[d]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic wait_init();
        int cnt  [NDUT];
        bit seen [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            cnt[d]  = 0;
            seen[d] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++)
                if (!seen[d]) begin
                    if (rdy[d]) seen[d] = 1'b1;
                    else        cnt[d]++;
                end
        end
        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if (!seen[d] || cnt[d] != depth_of(d) / 4) begin
                n_fail++;
                $display("FAIL init_len dut%0d: got %0d not-ready cycles (ready seen=%b), want %0d",
                         d, cnt[d], seen[d], depth_of(d) / 4);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic back_to_back();
        send(1'b1, 2'd2, 1'b0, 32'h04, 32'hCAFEF00D, 6'd0, 1'b0, 32'h0, 1'b0);
        send(1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        6'd1, 1'b0, 32'h0, 1'b0);
        send(1'b1, 2'd0, 1'b0, 32'h05, 32'h00000077, 6'd2, 1'b0, 32'h0, 1'b0);
        send(1'b0, 2'd1, 1'b1, 32'h04, 32'h0,        6'd3, 1'b0, 32'h0, 1'b0);
        send(1'b1, 2'd1, 1'b0, 32'h0A, 32'h00008001, 6'd4, 1'b0, 32'h0, 1'b0);
        send(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0,        6'd5, 1'b0, 32'h0, 1'b0);
        send(1'b0, 2'd0, 1'b1, 32'h05, 32'h0,        6'd6, 1'b0, 32'h0, 1'b0);
        send(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0,        6'd7, 1'b0, 32'h0, 1'b0);
        idle(12);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                n_vec++;
                if (rv[d]) begin
                    if (scb[d].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_resp dut%0d: got resp_valid=1 tag=%0d at cycle %0d, want no response",
                                 d, rtag[d], cyc);
                    end else begin
                        e = scb[d].pop_front();
                        if (rdat[d] != e.rdata || rtag[d] != e.tag || rerr[d] != e.err ||
                            rwe[d] != e.we || cyc != e.due) begin
                            n_fail++;
                            $display("FAIL resp dut%0d: got rdata=%h tag=%0d err=%b we=%b cyc=%0d, want rdata=%h tag=%0d err=%b we=%b cyc=%0d",
                                     d, rdat[d], rtag[d], rerr[d], rwe[d], cyc,
                                     e.rdata, e.tag, e.err, e.we, e.due);
                        end
                    end
                end else begin
                    if (rdat[d] != 32'h0 || rtag[d] != '0 || rerr[d] || rwe[d]) begin
                        n_fail++;
                        $display("FAIL idle_zero dut%0d: got rdata=%h tag=%0d err=%b we=%b, want all 0",
                                 d, rdat[d], rtag[d], rerr[d], rwe[d]);
                    end
                    if (scb[d].size() > 0 && scb[d][0].due < cyc) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL missing_resp dut%0d: got none by cycle %0d, want tag=%0d at cycle %0d",
                                 d, cyc, scb[d][0].tag, scb[d][0].due);
                        void'(scb[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_tag = '0;

        //  we    size   uns   addr          wdata          rdata          err
        add(1'b0, 2'd2, 1'b0, 32'h000,      32'h0,         32'h00000000, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h3FC,      32'h0,         32'h00000000, 1'b0);
        add(1'b1, 2'd2, 1'b0, 32'h080,      32'hDEADBEEF,  32'h00000000, 1'b0);
        add(1'b0, 2'd0, 1'b0, 32'h081,      32'h0,         32'hFFFFFFBE, 1'b0);
        add(1'b0, 2'd0, 1'b1, 32'h081,      32'h0,         32'h000000BE, 1'b0);
        add(1'b0, 2'd1, 1'b0, 32'h082,      32'h0,         32'hFFFFDEAD, 1'b0);
        add(1'b0, 2'd1, 1'b1, 32'h082,      32'h0,         32'h0000DEAD, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h080,      32'h0,         32'hDEADBEEF, 1'b0);
        add(1'b1, 2'd0, 1'b0, 32'h083,      32'h00000012,  32'h00000000, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h080,      32'h0,         32'h12ADBEEF, 1'b0);
        add(1'b0, 2'd0, 1'b0, 32'h083,      32'h0,         32'h00000012, 1'b0);
        add(1'b0, 2'd1, 1'b0, 32'h080,      32'h0,         32'hFFFFBEEF, 1'b0);
        add(1'b1, 2'd2, 1'b0, 32'h040,      32'h11223344,  32'h00000000, 1'b0);
        add(1'b0, 2'd1, 1'b0, 32'h041,      32'h0,         32'h00000000, 1'b1);
        add(1'b0, 2'd2, 1'b0, 32'h042,      32'h0,         32'h00000000, 1'b1);
        add(1'b1, 2'd2, 1'b0, 32'h042,      32'hAAAAAAAA,  32'h00000000, 1'b1);
        add(1'b1, 2'd1, 1'b0, 32'h041,      32'hBBBBBBBB,  32'h00000000, 1'b1);
        add(1'b1, 2'd3, 1'b0, 32'h040,      32'hFFFFFFFF,  32'h00000000, 1'b1);
        add(1'b0, 2'd2, 1'b0, 32'h400,      32'h0,         32'h00000000, 1'b1);
        add(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'hCCCCCCCC,  32'h00000000, 1'b1);
        add(1'b0, 2'd2, 1'b0, 32'h040,      32'h0,         32'h11223344, 1'b0);
        add(1'b0, 2'd1, 1'b1, 32'h040,      32'h0,         32'h00003344, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h3FC,      32'h0,         32'h00000000, 1'b0);
        add(1'b0, 2'd3, 1'b1, 32'h080,      32'h0,         32'h00000000, 1'b1);
        add(1'b0, 2'd2, 1'b0, 32'h080,      32'h0,         32'h12ADBEEF, 1'b0);
        add(1'b1, 2'd2, 1'b0, 32'h3FC,      32'h0BADF00D,  32'h00000000, 1'b0);
        add(1'b0, 2'd2, 1'b0, 32'h3FC,      32'h0,         32'h0BADF00D, 1'b0);

        @(posedge clk); #1;
        mon_en = 1'b1;
        do_reset(4);
        wait_init();

        for (int i = 0; i < tab.size(); i++)
            send(tab[i].we, tab[i].size, tab[i].uns, tab[i].addr, tab[i].wdata,
                 TAG_W'(i), 1'b1, tab[i].rdata, tab[i].err);
        idle(12);

        back_to_back();

        // Reset with loads still in flight; the stored word must be cleared by the sweep.
        send(1'b1, 2'd2, 1'b0, 32'h10, 32'h55AA55AA, 6'd20, 1'b0, 32'h0, 1'b0);
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        6'd21, 1'b0, 32'h0, 1'b0);
        idle(12);
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        6'd22, 1'b0, 32'h0, 1'b0);
        send(1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        6'd23, 1'b0, 32'h0, 1'b0);
        send(1'b0, 2'd2, 1'b0, 32'h18, 32'h0,        6'd24, 1'b0, 32'h0, 1'b0);
        do_reset(3);
        wait_init();
        send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        6'd25, 1'b0, 32'h0, 1'b0);
        idle(12);

        back_to_back();

        for (int d = 0; d < NDUT; d++) begin
            n_vec++;
            if (scb[d].size() != 0) begin
                n_fail++;
                $display("FAIL leftover dut%0d: got %0d responses outstanding, want 0", d, scb[d].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_data_mem.md
# lsu_data_mem

Parametrised, pipelined, byte-addressed data memory serving the load/store unit of the out-of-order core. Supports byte/half/word loads and stores with sign or zero extension, little-endian layout, tagged in-order responses after a fixed configurable latency, and error reporting for misaligned or out-of-range accesses. After reset it runs a hardware clear sweep before accepting requests. It replaces the single-cycle 32-byte scratch memory.

## Interface
- DEPTH_BYTES, 1024, memory size in bytes; power of two, multiple of 4, ≥ 32
- LATENCY, 2, cycles from request acceptance to response; 1..8
- TAG_W, 6, width of request/response tag (ROB/LSQ index)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes used per size
- req_tag  in  TAG_W  opaque tag returned with response
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_tag  out  TAG_W  tag of the responding request
- resp_err  out  1  request was misaligned, out of range or illegal size
- resp_we  out  1  echo of req_we for the responding request

## Operation
- States: INIT, RUN. reset → INIT with sweep pointer 0. INIT writes 0 to one 32-bit word per cycle; after the final word (DEPTH_BYTES/4 cycles) → RUN. req_ready = 1 only in RUN.
- Accept = req_valid && req_ready, at most one per cycle. Every accepted request produces exactly one response, in acceptance order.
- Error if any of: req_size = 11; half with addr[0] = 1; word with addr[1:0] ≠ 00; req_addr ≥ DEPTH_BYTES (full 32-bit compare, no wrap). On error: no memory write, resp_err = 1, resp_rdata = 0.
- Store: on the accept edge writes bytes addr..addr+n-1 (n = 1/2/4) from req_wdata[8n-1:0], little-endian; other bytes untouched.
- Load: reads bytes at the accept edge (pre-edge contents), assembles little-endian, extends from bit 7/15 per req_unsigned; word loads pass through.
- Load accepted the cycle after a store to the same bytes returns the new data; no same-cycle hazard exists.
- Reset at any time, including mid-INIT or with responses in flight: pipeline flushed, in-flight responses dropped (never emitted), sweep restarts at 0.

## Timing
- Reset values: req_ready 0, resp_valid 0, resp_rdata 0, resp_tag 0, resp_err 0, resp_we 0; all pipeline valid bits 0.
- First req_ready = 1 in the cycle after the final INIT write edge: reset deasserted at edge 0 → ready from edge DEPTH_BYTES/4 (256 cycles at default).
- Request accepted at edge k → resp_valid high for exactly the cycle following edge k+LATENCY-1 (LATENCY = 1: cycle immediately after acceptance).
- Throughput: one request per cycle sustained; no response backpressure; resp_* hold 0 when resp_valid = 0.

## Test plan
- Reset then idle: req_ready 0 for exactly 256 cycles (default), then 1; LW of 0x000, 0x3FC returns 0x00000000, err 0.
- SW 0x80 = 0xDEADBEEF, then LB 0x81 → 0xFFFFFFBE, LBU 0x81 → 0x000000BE, LH 0x82 → 0xFFFFDEAD, LHU 0x82 → 0x0000DEAD, LW 0x80 → 0xDEADBEEF; SB 0x83 = 0x12 then LW 0x80 → 0x12ADBEEF.
- LH 0x41, LW 0x42, size 11, LW 0x400, SW 0xFFFFFFFC: each resp_err 1, rdata 0; subsequent LW of touched words unchanged.
- Back-to-back: 8 consecutive requests tags 0..7 (store/load mix, store then same-address load next cycle): responses in tag order, one per cycle, each exactly LATENCY cycles after acceptance, load sees stored value.
- Reset asserted with 2 responses in flight: no resp_valid afterwards, req_ready 0 for full sweep, previously stored location reads 0.
- Rerun the back-to-back case at LATENCY = 1 and 8, DEPTH_BYTES = 32: latency and INIT length (8 cycles) scale accordingly.
